// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code decoder tracking held/press/release state for N_KEYS programmable keys.
// Latency: all outputs registered; they change on the edge that samples rx_valid=1.
// Backpressure: none; every rx_valid byte is consumed, release_all wins over a same-cycle byte.
module ps2_key_tracker #(
    parameter int                  N_KEYS         = 3,
    parameter logic [9*N_KEYS-1:0] KEY_CODES      = {9'h174, 9'h16B, 9'h05A},
    parameter int                  TIMEOUT_CYCLES = 50000,
    parameter int                  CNT_W          = 16
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              release_all,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              any_key_down,
    output logic              seq_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]       BYTE_E0 = 8'hE0;
    localparam logic [7:0]       BYTE_F0 = 8'hF0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_KEYS-1:0] down_q, down_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] rel_q, rel_d;
    logic              any_q;
    logic              err_q, err_d;

    // Decoded action of the current byte
    logic              dec_make;
    logic              dec_brk;
    logic [8:0]        dec_code;

    // Sequence FSM, timeout counter and key table update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        down_d   = down_q;
        press_d  = '0;
        rel_d    = '0;
        err_d    = 1'b0;
        dec_make = 1'b0;
        dec_brk  = 1'b0;
        dec_code = 9'h000;

        if (release_all) begin
            // Bulk release discards any byte arriving in the same cycle
            rel_d   = down_q;
            down_d  = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_data == BYTE_E0) begin
                        state_d = EXT;
                    end else if (rx_data == BYTE_F0) begin
                        state_d = BRK;
                    end else begin
                        dec_make = 1'b1;
                        dec_code = {1'b0, rx_data};
                    end
                end
                EXT: begin
                    if (rx_data == BYTE_F0) begin
                        state_d = EXT_BRK;
                    end else if (rx_data != BYTE_E0) begin
                        dec_make = 1'b1;
                        dec_code = {1'b1, rx_data};
                        state_d  = IDLE;
                    end
                end
                BRK: begin
                    if (rx_data == BYTE_F0) begin
                        err_d = 1'b1;
                    end else if (rx_data == BYTE_E0) begin
                        err_d   = 1'b1;
                        state_d = EXT;
                    end else begin
                        dec_brk  = 1'b1;
                        dec_code = {1'b0, rx_data};
                        state_d  = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (rx_data == BYTE_F0 || rx_data == BYTE_E0) begin
                        err_d = 1'b1;
                    end else begin
                        dec_brk  = 1'b1;
                        dec_code = {1'b1, rx_data};
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Stalled prefix: abandon it but keep held keys as they are
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Every matching table entry is updated; repeats of a held key are silent
        for (int i = 0; i < N_KEYS; i++) begin
            if (KEY_CODES[9*i +: 9] == dec_code) begin
                if (dec_make && !down_q[i]) begin
                    down_d[i]  = 1'b1;
                    press_d[i] = 1'b1;
                end
                if (dec_brk && down_q[i]) begin
                    down_d[i] = 1'b0;
                    rel_d[i]  = 1'b1;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            down_q  <= '0;
            press_q <= '0;
            rel_q   <= '0;
            any_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            down_q  <= down_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            any_q   <= |down_d;
            err_q   <= err_d;
        end
    end

    assign key_down     = down_q;
    assign key_press    = press_q;
    assign key_release  = rel_q;
    assign any_key_down = any_q;
    assign seq_error    = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       release_all;
    logic [2:0] key_down;
    logic [2:0] key_press;
    logic [2:0] key_release;
    logic       any_key_down;
    logic       seq_error;

    int n_assert;
    int n_fail;
    int n_press;
    int n_err;
    int err_at;

    ps2_key_tracker dut (
        .CLOCK_50     (clk),
        .Reset        (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .release_all  (release_all),
        .key_down     (key_down),
        .key_press    (key_press),
        .key_release  (key_release),
        .any_key_down (any_key_down),
        .seq_error    (seq_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All five outputs in one go
    task automatic check_all(input string tag, input logic [2:0] dn, input logic [2:0] pr,
                             input logic [2:0] rl, input logic any, input logic err);
        check({tag, ".down"},  {29'd0, key_down},     {29'd0, dn});
        check({tag, ".press"}, {29'd0, key_press},    {29'd0, pr});
        check({tag, ".rel"},   {29'd0, key_release},  {29'd0, rl});
        check({tag, ".any"},   {31'd0, any_key_down}, {31'd0, any});
        check({tag, ".err"},   {31'd0, seq_error},    {31'd0, err});
    endtask

    // Present one byte for one cycle; returns #1 after the sampling edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        release_all = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Enter press and release
        send(8'h5A); check_all("enter_make",  3'b001, 3'b001, 3'b000, 1'b1, 1'b0);
        send(8'hF0); check_all("enter_f0",    3'b001, 3'b000, 3'b000, 1'b1, 1'b0);
        send(8'h5A); check_all("enter_break", 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);

        // Left then Right held, Left released
        send(8'hE0); send(8'h6B); check_all("left_make",  3'b010, 3'b010, 3'b000, 1'b1, 1'b0);
        send(8'hE0); send(8'h74); check_all("right_make", 3'b110, 3'b100, 3'b000, 1'b1, 1'b0);
        send(8'hE0); check_all("lbrk_e0", 3'b110, 3'b000, 3'b000, 1'b1, 1'b0);
        send(8'hF0); check_all("lbrk_f0", 3'b110, 3'b000, 3'b000, 1'b1, 1'b0);
        send(8'h6B); check_all("left_break", 3'b100, 3'b000, 3'b010, 1'b1, 1'b0);
        idle_cycle(); check_all("left_break_gap", 3'b100, 3'b000, 3'b000, 1'b1, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h74);
        check_all("right_break", 3'b000, 3'b000, 3'b100, 1'b0, 1'b0);

        // Typematic repeats of Enter give one press only
        n_press = 0;
        for (int i = 0; i < 5; i++) begin
            send(8'h5A);
            if (key_press[0]) n_press++;
            check("typematic_down", {29'd0, key_down}, 32'h1);
        end
        check("typematic_presses", n_press, 1);
        send(8'h6B); check_all("plain_6b", 3'b001, 3'b000, 3'b000, 1'b1, 1'b0);
        send(8'hF0); send(8'h5A);
        check_all("typematic_break", 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);

        // Malformed break prefix: F0 F0 flags an error, then a break of an idle key is silent
        send(8'hF0); send(8'hF0); check_all("f0f0_err", 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        send(8'h5A); check_all("break_unheld", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

        // Stalled E0 prefix times out after 50000 idle cycles; held Enter survives
        send(8'h5A);
        send(8'hE0);
        n_err  = 0;
        err_at = 0;
        for (int k = 1; k <= 50000; k++) begin
            idle_cycle();
            if (seq_error) begin
                n_err++;
                err_at = k;
            end
        end
        check("timeout_count", n_err, 1);
        check("timeout_cycle", err_at, 50000);
        check("timeout_down", {29'd0, key_down}, 32'h1);
        send(8'h74); check_all("after_timeout_74", 3'b001, 3'b000, 3'b000, 1'b1, 1'b0);
        send(8'hF0); send(8'h5A);
        check_all("timeout_cleanup", 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);

        // Bulk release beats a same-cycle byte
        send(8'h5A); send(8'hE0); send(8'h74);
        check_all("hold_0_2", 3'b101, 3'b100, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        release_all = 1'b1;
        rx_data     = 8'hF0;
        rx_valid    = 1'b1;
        @(posedge clk);
        #1;
        release_all = 1'b0;
        rx_valid    = 1'b0;
        check_all("release_all", 3'b000, 3'b000, 3'b101, 1'b0, 1'b0);
        send(8'h5A); check_all("post_release_make", 3'b001, 3'b001, 3'b000, 1'b1, 1'b0);
        send(8'hF0); send(8'h5A);
        check_all("post_release_break", 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);

        // Asynchronous reset mid-sequence with Left held
        send(8'hE0); send(8'h6B); check_all("pre_reset_left", 3'b010, 3'b010, 3'b000, 1'b1, 1'b0);
        send(8'hE0);
        #3;
        rst = 1'b1;
        #1;
        check_all("async_reset", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle(); check_all("post_reset", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        send(8'h6B); check_all("post_reset_6b", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Parametrised PS/2 scan-code set 2 decoder. Consumes the byte stream from PS2_Controller (received_data / received_data_en).
- Tracks held/pressed/released state for N_KEYS programmable keys. Each key may be a normal or an E0-extended code.
- Adds typematic (auto-repeat) suppression, a stalled-sequence timeout, a sequence error flag and a bulk release. Feeds game control logic (Enter/Left/Right by default, extendable to more keys).

Parameters:
- N_KEYS, 3, number of tracked keys (1..16).
- KEY_CODES, {9'h174, 9'h16B, 9'h05A}, N_KEYS x 9-bit table. Entry i at bits [9i+8:9i]. Bit 8 = extended (E0) flag, bits 7:0 = make code. Defaults: key0 = Enter, key1 = Left, key2 = Right.
- TIMEOUT_CYCLES, 50000, idle clocks allowed between bytes of one multi-byte sequence (1 ms at 50 MHz).
- CNT_W, 16, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLOCK_50  in  1  system clock; all logic is clocked on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte from PS2_Controller.
- rx_valid  in  1  single-cycle strobe; rx_data is valid in that cycle.
- release_all  in  1  synchronous request to release every held key.
- key_down  out  N_KEYS  level: key i is currently held.
- key_press  out  N_KEYS  one-cycle pulse on the 0->1 transition of key_down[i].
- key_release  out  N_KEYS  one-cycle pulse on the 1->0 transition of key_down[i].
- any_key_down  out  1  OR-reduction of key_down, registered together with it.
- seq_error  out  1  one-cycle pulse on a malformed or timed-out sequence.

Behaviour:
- Reset: asynchronous assert forces all outputs to 0, FSM to IDLE and the timeout counter to 0. A reset in the middle of a sequence discards any partial prefix.
- FSM state transitions, evaluated only in cycles where rx_valid=1:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make(code={0,byte}), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> make(code={1,byte}), go to IDLE.
  - BRK: any byte other than E0/F0 -> break(code={0,byte}), go to IDLE. F0 -> stay BRK with seq_error. E0 -> go to EXT with seq_error.
  - EXT_BRK: any byte other than E0/F0 -> break(code={1,byte}), go to IDLE. E0 or F0 -> go to IDLE with seq_error.
- make(c): for every i with KEY_CODES[i]==c:
  - if key_down[i]==0, set key_down[i] and pulse key_press[i];
  - if key_down[i] is already 1 (typematic repeat), no pulse and no change.
- break(c): for every i with KEY_CODES[i]==c:
  - if key_down[i]==1, clear it and pulse key_release[i];
  - if key_down[i] is already 0, nothing happens.
- Unmatched codes are ignored. This covers AA (BAT pass), FA (ack), E1 (Pause prefix) and 00/FF, each treated as a plain byte in IDLE. Duplicate table entries all update.
- Latency: key_down, key_press, key_release, any_key_down and seq_error all change on the clock edge that samples rx_valid=1, i.e. they are visible the cycle after the strobe. All outputs are registered.
- Timeout:
  - The counter clears on every rx_valid and while in IDLE.
  - In EXT, BRK or EXT_BRK it increments each cycle without rx_valid.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse seq_error once, leave key_down unchanged.
- release_all=1: every set key_down bit clears and pulses its key_release bit in the same edge. The FSM returns to IDLE and the counter clears.
- release_all takes priority over rx_valid in the same cycle. That byte's decode is discarded (no press/release from it, no seq_error).
- The key_press and key_release pulses are never both 1 for the same key in one cycle.
- Any number of keys may be held simultaneously. No rollover limit below N_KEYS.

Test Plan:
- Reset, then bytes 5A, F0, 5A -> key_press[0] pulse and key_down=3'b001; then key_release[0] pulse and key_down=0. No seq_error.
- E0 6B, E0 74 (Left then Right held), then E0 F0 6B -> key_down goes 010, 110, 100; key_release[1] pulses once; any_key_down stays 1.
- Typematic: 5A sent 5 times -> exactly one key_press[0] pulse and key_down[0]=1 throughout. 6B without E0 -> no change to key1.
- E0, then 50000 idle cycles, then 74 -> seq_error pulses once at the timeout. The 74 then decodes as a normal make with no match, so key_down[2] stays 0.
- Hold keys 0 and 2, then assert release_all in the same cycle as rx_valid with byte F0 -> key_release=3'b101 pulse, key_down=0, FSM in IDLE, so a following 5A is a make.
- Assert Reset asynchronously between E0 and F0 while key1 is held -> outputs go 0 immediately, with no pulses after deassertion. A following 6B is ignored (no key1 press).
